// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit builder and the matching frame parser.
package udp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CSUM    = 3'd1,
    S_FOLD    = 3'd2,
    S_HEADER  = 3'd3,
    S_PAYLOAD = 3'd4,
    S_PAD     = 3'd5
  } udp_tx_state_t;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int IP_HDR_BYTES    = 20;
  localparam int UDP_HDR_BYTES   = 8;
  localparam int MIN_FRAME_BYTES = 60;
  localparam int HDR_BYTES       = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
  localparam int HDR_BITS        = 8 * HDR_BYTES;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

endpackage

// File: rtl/udp_tx_builder_ip_checksum.sv
// IPv4 header checksum: accumulates 16-bit words into a 20-bit sum and
// presents the folded one's-complement result combinationally.
module ip_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] result
);

  logic [19:0] acc_q;
  logic [19:0] acc_d;
  logic [16:0] fold_s;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = 20'd0;
    end else if (word_valid) begin
      acc_d = acc_q + {4'd0, word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 20'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Ten words cannot carry past bit 19, so two end-around folds suffice.
  always_comb begin
    fold_s = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    result = ~(fold_s[15:0] + {15'd0, fold_s[16]});
  end

endmodule

// File: rtl/udp_tx_builder.sv
// Builds an Ethernet II + IPv4 + UDP frame around a streamed payload and emits
// it byte-serially, MSB of the destination MAC first. The MAC appends the FCS.
module udp_tx_builder
  import udp_pkg::*;
#(
  parameter logic [47:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0101,
  parameter logic [31:0] DEST_IP     = 32'hC0A8_0102,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DEST_PORT   = 16'd5001,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic        start,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        err_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on every clock edge where valid && ready. valid never
  // waits on ready; data/last stay put while valid && !ready.
  udp_tx_state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [3:0]  csum_cnt_q, csum_cnt_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] pl_cnt_q, pl_cnt_d;
  logic [4:0]  pad_left_q, pad_left_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        err_len_q, err_len_d;

  logic [15:0] csum_word;
  logic [15:0] csum;
  logic [15:0] ip_len;
  logic [15:0] udp_len;
  logic [HDR_BITS-1:0] hdr_vec;
  logic [5:0]  hdr_sel;
  logic [8:0]  hdr_msb;
  logic [7:0]  hdr_byte;
  logic        len_ok;
  logic        no_pad;
  logic        last_pl;
  logic [4:0]  pad_init;

  assign ip_len   = 16'(IP_HDR_BYTES + UDP_HDR_BYTES) + len_q;
  assign udp_len  = 16'(UDP_HDR_BYTES) + len_q;
  assign len_ok   = (payload_len != 16'd0) && (payload_len <= 16'(MAX_PAYLOAD));
  assign no_pad   = len_q >= 16'(MIN_FRAME_BYTES - HDR_BYTES);
  assign last_pl  = pl_cnt_q == (len_q - 16'd1);
  assign pad_init = 5'(16'(MIN_FRAME_BYTES - HDR_BYTES) - len_q);

  always_comb begin
    csum_word = 16'h0000;
    case (csum_cnt_q)
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = ip_len;
      4'd2:    csum_word = ip_id_q;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL, IP_PROTO_UDP};
      4'd5:    csum_word = 16'h0000;
      4'd6:    csum_word = SRC_IP[31:16];
      4'd7:    csum_word = SRC_IP[15:0];
      4'd8:    csum_word = DEST_IP[31:16];
      4'd9:    csum_word = DEST_IP[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  ip_checksum u_csum (
    .clk        (main_clk),
    .rst        (main_rst),
    .clear      (state_q == S_IDLE),
    .word_valid (state_q == S_CSUM),
    .word       (csum_word),
    .result     (csum)
  );

  assign hdr_vec = {DEST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    16'h4500, ip_len, ip_id_q, 16'h4000, TTL, IP_PROTO_UDP, csum,
                    SRC_IP, DEST_IP,
                    SRC_PORT, DEST_PORT, udp_len, 16'h0000};

  // The byte loaded into the output register is always the one after the current.
  always_comb begin
    hdr_sel = 6'd0;
    if (state_q == S_HEADER && hdr_idx_q != 6'(HDR_BYTES - 1)) begin
      hdr_sel = hdr_idx_q + 6'd1;
    end
    hdr_msb  = 9'(HDR_BITS - 1) - {hdr_sel, 3'b000};
    hdr_byte = hdr_vec[hdr_msb -: 8];
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ip_id_d    = ip_id_q;
    csum_cnt_d = csum_cnt_q;
    hdr_idx_d  = hdr_idx_q;
    pl_cnt_d   = pl_cnt_q;
    pad_left_d = pad_left_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    err_len_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d      = payload_len;
            csum_cnt_d = 4'd0;
            hdr_idx_d  = 6'd0;
            state_d    = S_CSUM;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      S_CSUM: begin
        csum_cnt_d = csum_cnt_q + 4'd1;
        if (csum_cnt_q == 4'd9) begin
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        tx_data_d  = hdr_byte;
        tx_valid_d = 1'b1;
        tx_last_d  = 1'b0;
        state_d    = S_HEADER;
      end
      S_HEADER: begin
        if (tx_valid_q && tx_ready) begin
          if (hdr_idx_q == 6'(HDR_BYTES - 1)) begin
            pl_cnt_d   = 16'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'd0;
            state_d    = S_PAYLOAD;
          end else begin
            hdr_idx_d = hdr_sel;
            tx_data_d = hdr_byte;
          end
        end
      end
      S_PAYLOAD: begin
        if (pl_valid && tx_ready) begin
          pl_cnt_d = pl_cnt_q + 16'd1;
          if (last_pl) begin
            if (no_pad) begin
              ip_id_d = ip_id_q + 16'd1;
              state_d = S_IDLE;
            end else begin
              pad_left_d = pad_init;
              tx_data_d  = 8'd0;
              tx_valid_d = 1'b1;
              tx_last_d  = (pad_init == 5'd1);
              state_d    = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (tx_valid_q && tx_ready) begin
          if (pad_left_q == 5'd1) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            ip_id_d    = ip_id_q + 16'd1;
            state_d    = S_IDLE;
          end else begin
            pad_left_d = pad_left_q - 5'd1;
            tx_last_d  = (pad_left_q == 5'd2);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      ip_id_q    <= 16'd0;
      csum_cnt_q <= 4'd0;
      hdr_idx_q  <= 6'd0;
      pl_cnt_q   <= 16'd0;
      pad_left_q <= 5'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ip_id_q    <= ip_id_d;
      csum_cnt_q <= csum_cnt_d;
      hdr_idx_q  <= hdr_idx_d;
      pl_cnt_q   <= pl_cnt_d;
      pad_left_q <= pad_left_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      err_len_q  <= err_len_d;
    end
  end

  // Payload bytes bypass the output register so the stream costs no bubble.
  always_comb begin
    if (state_q == S_PAYLOAD) begin
      tx_data  = pl_data;
      tx_valid = pl_valid;
      tx_last  = last_pl && no_pad;
      pl_ready = tx_ready;
    end else begin
      tx_data  = tx_data_q;
      tx_valid = tx_valid_q;
      tx_last  = tx_last_q;
      pl_ready = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign err_len   = err_len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_udp_tx_builder.sv
// Self-checking bench for udp_tx_builder: random payloads and stalls compared
// against a byte-image model of the Ethernet/IPv4/UDP frame.
module tb_udp_tx_builder;
  import udp_pkg::*;

  localparam logic [47:0] P_DEST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] P_SRC_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [31:0] P_SRC_IP    = 32'hC0A8_0101;
  localparam logic [31:0] P_DEST_IP   = 32'hC0A8_0102;
  localparam logic [15:0] P_SRC_PORT  = 16'd5000;
  localparam logic [15:0] P_DEST_PORT = 16'd5001;
  localparam logic [7:0]  P_TTL       = 8'd64;

  logic        main_clk;
  logic        main_rst;
  logic        start;
  logic [15:0] payload_len;
  logic        busy;
  logic        err_len;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [2:0]  dbg_state;

  udp_tx_builder dut (
    .main_clk    (main_clk),
    .main_rst    (main_rst),
    .start       (start),
    .payload_len (payload_len),
    .busy        (busy),
    .err_len     (err_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic [7:0]  img_q[$];
  logic [7:0]  pl_q[$];
  logic [15:0] exp_id = 16'd0;
  int          cur_len = 0;
  int          first_valid_cyc = -1;
  int          last_cyc = 0;
  int          hold_viol = 0;
  int          prdy_viol = 0;
  bit          hold_prev = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;
  bit          frame_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] got16(input int idx);
    return {got_q[idx][7:0], got_q[idx+1][7:0]};
  endfunction

  // ---------------- reference model ----------------
  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) img_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_expected(input int len, input logic [15:0] id);
    int unsigned sum;
    logic [15:0] csum;
    img_q.delete();
    push_be(P_DEST_MAC, 6);
    push_be(P_SRC_MAC, 6);
    push_be(48'h0800, 2);
    push_be(48'h4500, 2);
    push_be(48'(28 + len), 2);
    push_be(48'(id), 2);
    push_be(48'h4000, 2);
    push_be(48'({P_TTL, 8'h11}), 2);
    push_be(48'h0000, 2);
    push_be(48'(P_SRC_IP), 4);
    push_be(48'(P_DEST_IP), 4);
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += 32'({img_q[i], img_q[i+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    csum = ~sum[15:0];
    img_q[24] = csum[15:8];
    img_q[25] = csum[7:0];
    push_be(48'(P_SRC_PORT), 2);
    push_be(48'(P_DEST_PORT), 2);
    push_be(48'(8 + len), 2);
    push_be(48'h0000, 2);
    for (int i = 0; i < len; i++) img_q.push_back(pl_q[i]);
    while (img_q.size() < 60) img_q.push_back(8'h00);
    exp_q.delete();
    for (int i = 0; i < img_q.size(); i++) exp_q.push_back({(i == img_q.size() - 1), img_q[i]});
  endtask

  task automatic fill_payload(input int len);
    pl_q.delete();
    for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- monitor ----------------
  bit in_pl;
  always @(negedge main_clk) begin
    if (main_rst) begin
      hold_prev = 1'b0;
    end else begin
      in_pl = (got_q.size() >= 42) && (got_q.size() < 42 + cur_len);
      if (hold_prev && (!tx_valid || tx_data !== hold_data || tx_last !== hold_last)) hold_viol++;
      hold_prev = tx_valid && !tx_ready && !in_pl;
      hold_data = tx_data;
      hold_last = tx_last;
      if (pl_ready && !in_pl) prdy_viol++;
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tx_valid && tx_ready) begin
        got_q.push_back({tx_last, tx_data});
        last_cyc = cyc;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_payload(input int len, input bit stall);
    int idx = 0;
    while (idx < len && !frame_done) begin
      @(posedge main_clk); #1;
      pl_data  = pl_q[idx];
      pl_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge main_clk);
      if (pl_valid && pl_ready) idx++;
    end
    @(posedge main_clk); #1;
    pl_valid = 1'b0;
  endtask

  task automatic drive_ready(input bit stall);
    while (!frame_done) begin
      @(posedge main_clk); #1;
      tx_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic run_frame(input int len, input bit stall, input int abort_at);
    int start_cyc;
    int guard;
    build_expected(len, exp_id);
    got_q.delete();
    cur_len = len;
    first_valid_cyc = -1;
    hold_viol = 0;
    prdy_viol = 0;
    frame_done = 1'b0;
    @(posedge main_clk); #1;
    start = 1'b1;
    payload_len = 16'(len);
    @(posedge main_clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    fork
      drive_payload(len, stall);
      drive_ready(stall);
      begin
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 20000 &&
               !(abort_at > 0 && got_q.size() >= abort_at)) begin
          @(negedge main_clk);
          guard++;
        end
        if (abort_at > 0) begin
          #2 main_rst = 1'b1;
          #1;
          check_eq("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
          check_eq("rst_mid_busy", 32'(busy), 32'd0);
          check_eq("rst_mid_pl_ready", 32'(pl_ready), 32'd0);
        end
        frame_done = 1'b1;
      end
    join
    if (abort_at > 0) begin
      @(posedge main_clk); #1;
      main_rst = 1'b0;
      exp_id = 16'd0;
    end else begin
      check_eq("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check_eq($sformatf("len%0d_byte%0d", len, i), 32'(got_q[i]), 32'(exp_q[i]));
      check_eq("first_byte_latency", 32'(first_valid_cyc - start_cyc), 32'd11);
      if (!stall) check_eq("frame_duration", 32'(last_cyc - start_cyc), 32'(10 + exp_q.size()));
      check_eq("stall_hold", 32'(hold_viol), 32'd0);
      check_eq("pl_ready_phase", 32'(prdy_viol), 32'd0);
      @(posedge main_clk); #1;
      check_eq("busy_after_frame", 32'(busy), 32'd0);
      exp_id = exp_id + 16'd1;
    end
  endtask

  task automatic err_start(input logic [15:0] len);
    int vcount = 0;
    @(posedge main_clk); #1;
    start = 1'b1;
    payload_len = len;
    @(posedge main_clk); #1;
    start = 1'b0;
    check_eq("err_len_pulse", 32'(err_len), 32'd1);
    check_eq("err_busy", 32'(busy), 32'd0);
    @(posedge main_clk); #1;
    check_eq("err_len_single", 32'(err_len), 32'd0);
    repeat (15) begin
      @(negedge main_clk);
      if (tx_valid) vcount++;
    end
    check_eq("err_no_tx", 32'(vcount), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0;
    payload_len = 16'd0;
    pl_data = 8'd0;
    pl_valid = 1'b0;
    tx_ready = 1'b0;
    main_rst = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err_len", 32'(err_len), 32'd0);
    check_eq("rst_pl_ready", 32'(pl_ready), 32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_last", 32'(tx_last), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    main_rst = 1'b0;

    pl_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(4, 1'b0, 0);
    check_eq("f1_ip_len", 32'(got16(16)), 32'h0020);
    check_eq("f1_csum", 32'(got16(24)), 32'hB779);
    check_eq("f1_udp_len", 32'(got16(38)), 32'h000C);
    check_eq("f1_last", 32'(got_q[59][8]), 32'd1);

    run_frame(4, 1'b0, 0);
    check_eq("f2_ip_id", 32'(got16(18)), 32'h0001);
    check_eq("f2_csum", 32'(got16(24)), 32'hB778);

    fill_payload(18);
    run_frame(18, 1'b0, 0);
    check_eq("len18_size", 32'(got_q.size()), 32'd60);
    check_eq("len18_last", 32'(got_q[59][8]), 32'd1);

    err_start(16'd0);
    err_start(16'd1473);

    fill_payload(100);
    run_frame(100, 1'b0, 0);
    run_frame(100, 1'b1, 0);

    fill_payload(17);
    run_frame(17, 1'b1, 0);
    fill_payload(1);
    run_frame(1, 1'b1, 0);
    fill_payload(1472);
    run_frame(1472, 1'b0, 0);
    for (int r = 0; r < 5; r++) begin
      int rl;
      rl = $urandom_range(1, 200);
      fill_payload(rl);
      run_frame(rl, 1'b1, 0);
    end

    fill_payload(100);
    run_frame(100, 1'b0, 60);
    pl_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(4, 1'b0, 0);
    check_eq("post_rst_ip_id", 32'(got16(18)), 32'h0000);
    check_eq("post_rst_csum", 32'(got16(24)), 32'hB779);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
